// File: rtl/mem_arbiter.sv
// Two-master arbiter (I-cache, D-cache) for a shared pipelined main memory.
// Define ARB_ROUND_ROBIN_EN for round-robin priority; default is fixed D-cache priority.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_MemRead,
  input  logic [ADDR_W-1:0] icache_mem_addr,
  output logic              icache_grant,
  output logic              icache_MemDataValid,
  output logic [DATA_W-1:0] icache_mem_read_data,
  input  logic              dcache_MemRead,
  input  logic              dcache_MemWrite,
  input  logic [ADDR_W-1:0] dcache_mem_addr,
  input  logic [DATA_W-1:0] dcache_mem_write_data,
  output logic              dcache_grant,
  output logic              dcache_MemDataValid,
  output logic [DATA_W-1:0] dcache_mem_read_data,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] I_FILL  = 2'd1;
  localparam logic [1:0] D_FILL  = 2'd2;
  localparam logic [1:0] D_WRITE = 2'd3;

  localparam logic PRIO_I = 1'b0;
  localparam logic PRIO_D = 1'b1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic             d_req;
  logic [1:0]       d_target;

  assign d_req    = dcache_MemRead | dcache_MemWrite;
  assign d_target = dcache_MemRead ? D_FILL : D_WRITE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (prio_q == PRIO_D) begin
          if (d_req)               state_d = d_target;
          else if (icache_MemRead) state_d = I_FILL;
        end else begin
          if (icache_MemRead)      state_d = I_FILL;
          else if (d_req)          state_d = d_target;
        end
      end
      I_FILL, D_FILL: begin
        // Beats are counted even if the owner dropped MemRead: data is already in flight.
        if (mem_data_valid) begin
          if (cnt_q == CNT_W'(BLOCK_WORDS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_d  = (state_q == I_FILL) ? PRIO_D : PRIO_I;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        prio_d  = PRIO_I;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prio_q  <= PRIO_D;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    icache_grant         = 1'b0;
    icache_MemDataValid  = 1'b0;
    icache_mem_read_data = '0;
    dcache_grant         = 1'b0;
    dcache_MemDataValid  = 1'b0;
    dcache_mem_read_data = '0;
    mem_enable           = 1'b0;
    mem_wr               = 1'b0;
    mem_addr             = '0;
    mem_data_in          = '0;
    case (state_q)
      I_FILL: begin
        icache_grant         = 1'b1;
        mem_enable           = icache_MemRead;
        mem_addr             = icache_mem_addr;
        icache_MemDataValid  = mem_data_valid;
        icache_mem_read_data = mem_data_out;
      end
      D_FILL: begin
        dcache_grant         = 1'b1;
        mem_enable           = dcache_MemRead;
        mem_addr             = dcache_mem_addr;
        dcache_MemDataValid  = mem_data_valid;
        dcache_mem_read_data = mem_data_out;
      end
      D_WRITE: begin
        dcache_grant = 1'b1;
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = dcache_mem_addr;
        mem_data_in  = dcache_mem_write_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BW = 8;

  localparam int O_NONE = 0;
  localparam int O_IF   = 1;
  localparam int O_DF   = 2;
  localparam int O_DW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          icache_MemRead = 1'b0;
  logic [AW-1:0] icache_mem_addr = '0;
  logic          icache_grant, icache_MemDataValid;
  logic [DW-1:0] icache_mem_read_data;
  logic          dcache_MemRead = 1'b0, dcache_MemWrite = 1'b0;
  logic [AW-1:0] dcache_mem_addr = '0;
  logic [DW-1:0] dcache_mem_write_data = '0;
  logic          dcache_grant, dcache_MemDataValid;
  logic [DW-1:0] dcache_mem_read_data;
  logic          mem_enable, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_data_valid = 1'b0;
  logic [DW-1:0] mem_data_out = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst),
    .icache_MemRead(icache_MemRead), .icache_mem_addr(icache_mem_addr),
    .icache_grant(icache_grant), .icache_MemDataValid(icache_MemDataValid),
    .icache_mem_read_data(icache_mem_read_data),
    .dcache_MemRead(dcache_MemRead), .dcache_MemWrite(dcache_MemWrite),
    .dcache_mem_addr(dcache_mem_addr), .dcache_mem_write_data(dcache_mem_write_data),
    .dcache_grant(dcache_grant), .dcache_MemDataValid(dcache_MemDataValid),
    .dcache_mem_read_data(dcache_mem_read_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: who currently owns memory, how many fill beats are still owed, who is preferred.
  int owner     = O_NONE;
  int beats_owed = 0;
  bit prefer_d  = 1'b1;
  int i_beats_seen = 0;
  int d_beats_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner      = O_NONE;
    beats_owed = 0;
    prefer_d   = 1'b1;
  endtask

  task automatic finish_txn(input bool_served_d);
`ifdef ARB_ROUND_ROBIN_EN
    prefer_d = !bool_served_d;
`endif
    owner = O_NONE;
  endtask

  task automatic model_update();
    bit want_d;
    if (!rst) begin
      model_reset();
      return;
    end
    want_d = dcache_MemRead || dcache_MemWrite;
    if (owner == O_NONE) begin
      if (want_d && (!icache_MemRead || prefer_d)) begin
        owner      = dcache_MemRead ? O_DF : O_DW;
        beats_owed = BW;
      end else if (icache_MemRead) begin
        owner      = O_IF;
        beats_owed = BW;
      end
    end else if (owner == O_DW) begin
      finish_txn(1'b1);
    end else if (mem_data_valid) begin
      beats_owed--;
      if (beats_owed == 0) finish_txn(owner == O_DF);
    end
  endtask

  task automatic check_outputs();
    logic eig, edg, een, ewr, eiv, edv;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, eid, edd;
    {eig, edg, een, ewr, eiv, edv} = '0;
    ea = '0; ed = '0; eid = '0; edd = '0;
    if (owner == O_IF) begin
      eig = 1'b1; een = icache_MemRead; ea = icache_mem_addr;
      eiv = mem_data_valid; eid = mem_data_out;
    end else if (owner == O_DF) begin
      edg = 1'b1; een = dcache_MemRead; ea = dcache_mem_addr;
      edv = mem_data_valid; edd = mem_data_out;
    end else if (owner == O_DW) begin
      edg = 1'b1; een = 1'b1; ewr = 1'b1;
      ea = dcache_mem_addr; ed = dcache_mem_write_data;
    end
    check("grant",       64'({icache_grant, dcache_grant}), 64'({eig, edg}));
    check("mem_ctl",     64'({mem_enable, mem_wr}), 64'({een, ewr}));
    check("mem_addr",    64'(mem_addr), 64'(ea));
    check("mem_data_in", 64'(mem_data_in), 64'(ed));
    check("icache_rd",   64'({icache_MemDataValid, icache_mem_read_data}), 64'({eiv, eid}));
    check("dcache_rd",   64'({dcache_MemDataValid, dcache_mem_read_data}), 64'({edv, edd}));
    if (icache_MemDataValid) i_beats_seen++;
    if (dcache_MemDataValid) d_beats_seen++;
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Drive beats and release each request once its transaction has been served.
  task automatic serve(input int max_cycles, input bit always_valid);
    int c = 0;
    int prev;
    while ((icache_MemRead || dcache_MemRead || dcache_MemWrite || owner != O_NONE)
           && c < max_cycles) begin
      mem_data_valid = always_valid ? 1'b1 : 1'($urandom_range(0, 1));
      mem_data_out   = DW'($urandom);
      prev = owner;
      step();
      c++;
      if (prev == O_IF && owner != O_IF) icache_MemRead = 1'b0;
      if (prev == O_DF && owner != O_DF) dcache_MemRead = 1'b0;
      if (prev == O_DW) dcache_MemWrite = 1'b0;
    end
    check("serve_done",
          64'({icache_MemRead, dcache_MemRead, dcache_MemWrite, owner != O_NONE}), 64'(0));
    mem_data_valid = 1'b0;
  endtask

  task automatic drive_random();
    bit d_pend;
    if (owner == O_IF) begin
      icache_MemRead  = ($urandom_range(0, 7) != 0);
      icache_mem_addr = AW'($urandom);
    end else if (!icache_MemRead && $urandom_range(0, 3) == 0) begin
      icache_MemRead  = 1'b1;
      icache_mem_addr = AW'($urandom);
    end
    d_pend = (dcache_MemRead || dcache_MemWrite);
    if (owner == O_DF) begin
      dcache_MemRead  = ($urandom_range(0, 7) != 0);
      dcache_MemWrite = 1'b0;
      dcache_mem_addr = AW'($urandom);
    end else if (owner == O_DW) begin
      dcache_MemWrite = ($urandom_range(0, 3) == 0);
      dcache_mem_addr = AW'($urandom);
      dcache_mem_write_data = DW'($urandom);
    end else if (!d_pend && $urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 2))
        0:       begin dcache_MemRead = 1'b1; dcache_MemWrite = 1'b0; end
        1:       begin dcache_MemRead = 1'b0; dcache_MemWrite = 1'b1; end
        default: begin dcache_MemRead = 1'b1; dcache_MemWrite = 1'b1; end
      endcase
      dcache_mem_addr       = AW'($urandom);
      dcache_mem_write_data = DW'($urandom);
    end
    mem_data_valid = 1'($urandom_range(0, 1));
    mem_data_out   = DW'($urandom);
  endtask

  initial begin
    int k;
    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 1'b1;

    // Single I-cache fill with data 1..8.
    i_beats_seen = 0; d_beats_seen = 0;
    icache_MemRead = 1'b1; icache_mem_addr = 16'h0000;
    step();
    for (int b = 1; b <= BW; b++) begin
      mem_data_valid = 1'b1; mem_data_out = DW'(b);
      step();
    end
    mem_data_valid = 1'b0; icache_MemRead = 1'b0;
    step();
    check("i_fill_beats", 64'(i_beats_seen), 64'(BW));
    check("i_fill_d_beats", 64'(d_beats_seen), 64'(0));

    // Two simultaneous pairs of fill requests.
    for (int p = 0; p < 2; p++) begin
      i_beats_seen = 0; d_beats_seen = 0;
      icache_MemRead = 1'b1; icache_mem_addr = 16'h0100;
      dcache_MemRead = 1'b1; dcache_mem_addr = 16'h0200;
      serve(60, 1'b1);
      check("pair_i_beats", 64'(i_beats_seen), 64'(BW));
      check("pair_d_beats", 64'(d_beats_seen), 64'(BW));
    end

    // D-cache write arriving at beat 3 of an I fill.
    icache_MemRead = 1'b1; icache_mem_addr = 16'h0300;
    k = 0;
    while (!(owner == O_IF && beats_owed == BW - 3) && k < 20) begin
      mem_data_valid = (owner == O_IF); mem_data_out = DW'($urandom);
      step(); k++;
    end
    check("i_fill_reach_beat3", 64'(beats_owed), 64'(BW - 3));
    dcache_MemWrite = 1'b1; dcache_mem_addr = 16'h0010; dcache_mem_write_data = 16'hBEEF;
    serve(40, 1'b1);

    // D-cache read and write together select the fill, then the write follows.
    d_beats_seen = 0;
    dcache_MemRead = 1'b1; dcache_MemWrite = 1'b1;
    dcache_mem_addr = 16'h0400; dcache_mem_write_data = 16'h1234;
    step();
    check("rw_selects_fill", 64'({dcache_grant, mem_wr}), 64'(2'b10));
    serve(40, 1'b1);
    check("rw_fill_beats", 64'(d_beats_seen), 64'(BW));

    // Reset after beat 4 of a D fill; the remaining beats must be dropped.
    dcache_MemRead = 1'b1; dcache_mem_addr = 16'h0500;
    step();
    for (int b = 1; b <= 4; b++) begin
      mem_data_valid = 1'b1; mem_data_out = DW'(b);
      step();
    end
    rst = 1'b0;
    model_reset();
    dcache_MemRead = 1'b0;
    for (int b = 5; b <= 6; b++) begin
      mem_data_out = DW'(b);
      step();
    end
    rst = 1'b1;
    i_beats_seen = 0; d_beats_seen = 0;
    for (int b = 7; b <= 8; b++) begin
      mem_data_out = DW'(b);
      step();
    end
    check("post_reset_dropped", 64'(i_beats_seen + d_beats_seen), 64'(0));
    mem_data_valid = 1'b0;
    dcache_MemRead = 1'b1; dcache_mem_addr = 16'h0600;
    serve(60, 1'b0);
    check("post_reset_fill_beats", 64'(d_beats_seen), 64'(BW));

    // Stray beats in IDLE, then a fill with sparse beats counts exactly BLOCK_WORDS.
    i_beats_seen = 0;
    for (int s = 0; s < 3; s++) begin
      mem_data_valid = 1'b1; mem_data_out = DW'($urandom);
      step();
    end
    check("stray_dropped", 64'(i_beats_seen), 64'(0));
    icache_MemRead = 1'b1; icache_mem_addr = 16'h0700;
    mem_data_valid = 1'b0;
    step();
    serve(80, 1'b0);
    check("stray_then_fill_beats", 64'(i_beats_seen), 64'(BW));

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        model_reset();
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
